// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - shared register-file geometry and dump FSM encoding
// Optional macro REG_DUMP_CHECKSUM_EN adds the CSUM state.
package reg_dump_reader_pkg;

    localparam int RS_WIDTH       = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_SIZE       = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_READ,
        ST_SEND,
        ST_DONE
`ifdef REG_DUMP_CHECKSUM_EN
        ,
        ST_CSUM
`endif
    } dump_state_e;

    function automatic logic is_last_index(input logic [RS_WIDTH-1:0] idx);
        return idx == RS_WIDTH'(REG_SIZE - 1);
    endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - dump output stream (valid/ready beat with index and flags)
// out_csum is only ever set when REG_DUMP_CHECKSUM_EN is defined.
interface reg_dump_reader_if;
    import reg_dump_reader_pkg::*;

    logic                      out_valid;
    logic                      out_ready;
    logic [REG_DATA_WIDTH-1:0] out_data;
    logic [RS_WIDTH-1:0]       out_index;
    logic                      out_last;
    logic                      out_csum;

    modport master (
        output out_valid, out_data, out_index, out_last, out_csum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_index, out_last, out_csum,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_reader_csum_acc.sv
// rtl/reg_dump_reader_csum_acc.sv - XOR accumulator with clear/enable for the dump checksum
// Instantiated by reg_dump_reader only when REG_DUMP_CHECKSUM_EN is defined.
module dump_csum_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] acc
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc ^ din;
        end
    end
endmodule

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - halts the core and streams registers 0..REG_SIZE-1 from a spare read port
// REG_DUMP_CHECKSUM_EN appends an XOR checksum beat flagged with out_csum.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      halt_req,
    input  logic                      halt_ack,
    output logic [RS_WIDTH-1:0]       rd_addr,
    input  logic [REG_DATA_WIDTH-1:0] rd_data,
    reg_dump_reader_if.master         stream,
    output logic                      busy,
    output logic                      done
);
    dump_state_e               state_q, state_d;
    logic [RS_WIDTH-1:0]       index_q;
    logic                      idx_clr, idx_inc, load_beat;
    logic [REG_DATA_WIDTH-1:0] data_q;
    logic [RS_WIDTH-1:0]       beat_index_q;
    logic                      last_q;
    logic                      csum_flag_q;
    logic                      out_valid;

`ifdef REG_DUMP_CHECKSUM_EN
    logic                      csum_clr, csum_en, load_csum;
    logic [REG_DATA_WIDTH-1:0] csum_acc;

    dump_csum_acc #(.WIDTH(REG_DATA_WIDTH)) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (csum_clr),
        .enable (csum_en),
        .din    (rd_data),
        .acc    (csum_acc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        halt_req  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        load_beat = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_clr  = 1'b0;
        csum_en   = 1'b0;
        load_csum = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HALT;
                    idx_clr = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_clr = 1'b1;
`endif
                end
            end
            ST_HALT: begin
                halt_req = 1'b1;
                busy     = 1'b1;
                if (halt_ack) state_d = ST_READ;
            end
            ST_READ: begin
                halt_req  = 1'b1;
                busy      = 1'b1;
                rd_addr   = index_q;
                load_beat = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_en   = 1'b1;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                halt_req  = 1'b1;
                busy      = 1'b1;
                out_valid = 1'b1;
                if (stream.out_ready) begin
                    // Terminal test comes before the increment, so the index never wraps.
                    if (is_last_index(index_q)) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d   = ST_CSUM;
                        load_csum = 1'b1;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        idx_inc = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                halt_req  = 1'b1;
                busy      = 1'b1;
                out_valid = 1'b1;
                if (stream.out_ready) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q      <= '0;
            data_q       <= '0;
            beat_index_q <= '0;
            last_q       <= 1'b0;
            csum_flag_q  <= 1'b0;
        end else begin
            if (idx_clr) begin
                index_q <= '0;
            end else if (idx_inc) begin
                index_q <= index_q + 1'b1;
            end
            if (load_beat) begin
                data_q       <= rd_data;
                beat_index_q <= index_q;
                csum_flag_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
                last_q       <= 1'b0;
            end else if (load_csum) begin
                data_q       <= csum_acc;
                beat_index_q <= '0;
                last_q       <= 1'b1;
                csum_flag_q  <= 1'b1;
`else
                last_q       <= is_last_index(index_q);
`endif
            end
        end
    end

    assign stream.out_valid = out_valid;
    assign stream.out_data  = data_q;
    assign stream.out_index = beat_index_q;
    assign stream.out_last  = last_q;
    assign stream.out_csum  = csum_flag_q;
endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug readout engine that sits on a spare read port of the integer register file. On a start pulse it stalls the core, then reads registers 0 through REG_SIZE-1 in ascending order. It streams each value out over a valid/ready interface to a debug host or UART bridge, then releases the core. It is the consumer (reader) side of the register file's read port, used for post-mortem and single-step inspection.

## Interface
- RS_WIDTH, 5, register index width
- REG_DATA_WIDTH, 32, register data width
- REG_SIZE, 32, number of registers dumped (must equal 2**RS_WIDTH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle dump request
- halt_req  out  1  request core to stop retiring/writing registers
- halt_ack  in  1  core confirms it is stalled
- rd_addr  out  RS_WIDTH  register file read address
- rd_data  in  REG_DATA_WIDTH  register file read data (combinational, same cycle as rd_addr)
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  REG_DATA_WIDTH  register value (or checksum)
- out_index  out  RS_WIDTH  register index of beat
- out_last  out  1  final beat of dump
- out_csum  out  1  beat is checksum (tied 0 when feature absent)
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse on dump completion

## Operation
- States: IDLE, HALT, READ, SEND, CSUM (only with macro), DONE.
- IDLE: start=1 -> HALT; halt_req=1, busy=1, index counter cleared to 0, checksum cleared.
- HALT: wait for halt_ack=1 -> READ. No timeout.
- READ (1 cycle): rd_addr=index; rd_data is captured into out_data, index into out_index; out_last=(index==REG_SIZE-1) without macro; checksum ^= rd_data -> SEND.
- SEND: out_valid=1; payload held stable until out_valid&&out_ready. On handshake: if index==REG_SIZE-1, go to CSUM (macro) or DONE; else index+1 -> READ.
- CSUM: out_data=checksum, out_index=0, out_csum=1, out_last=1, out_valid=1, held until handshake -> DONE.
- DONE (1 cycle): done=1, halt_req=0, busy=0 -> IDLE.
- Index 0 is read like any other register; whatever rd_data returns is emitted (expected 0).
- start while busy: ignored, no queuing.
- halt_ack is only sampled in HALT; deassertion afterwards is a core protocol error, not checked, and the dump continues.
- Index counter is RS_WIDTH bits; it never wraps because the terminal test precedes increment.

## Timing
- Reset: all outputs 0 (rd_addr=0, out_data=0, out_index=0, flags 0), state IDLE, on the first clk edge with rst=1.
- rst mid-dump aborts immediately: halt_req, out_valid and busy drop to 0 in the cycle after the edge; no done pulse.
- start -> halt_req: 1 cycle. halt_ack high -> first out_valid: 2 cycles (HALT->READ->SEND).
- Throughput with out_ready held high: one beat per 2 cycles. Full dump is 2*REG_SIZE cycles after HALT exits (+1 beat with macro).
- out_valid, once high, stays high with stable payload until accepted.
- halt_req remains high through the final handshake and drops in the cycle done pulses.

## Configuration
- REG_DUMP_CHECKSUM_EN defined: one extra CSUM beat carrying the XOR of all REG_SIZE dumped words. out_last is asserted only on that beat, and out_csum=1 on it.
- Undefined: no CSUM state or accumulator; out_last is on index REG_SIZE-1; out_csum is constant 0.

## Structure
- RS_WIDTH, REG_DATA_WIDTH and REG_SIZE come from the shared riscv_def definitions.
- The dump FSM state encoding belongs in the shared package for debug-module reuse.
- One natural sub-module: dump_csum_acc (XOR accumulator with clear/enable), instantiated only under REG_DUMP_CHECKSUM_EN.

## Test plan
- Preload x1..x31 = 0x1000_0000+i, x0=0; start, halt_ack after 3 cycles, out_ready=1 -> 32 beats, index 0..31, data 0,0x1000_0001..0x1000_001F, out_last only on index 31, done once.
- Same preload, out_ready toggling 1-0-0-1 -> each beat held stable while ready=0; no beat dropped or duplicated.
- halt_ack held 0 for 50 cycles -> halt_req=1 and out_valid=0 throughout; first beat 2 cycles after halt_ack rises.
- start pulsed again at beat 10 -> ignored; exactly 32 beats and one done.
- rst asserted during beat 5 SEND -> next cycle halt_req=0, out_valid=0, busy=0, no done; a new start produces a full dump from index 0.
- With REG_DUMP_CHECKSUM_EN, all registers = 0xA5A5_A5A5 except x0=0 -> 33rd beat data = 0xA5A5_A5A5 (31 odd terms), out_csum=1, out_last=1; index 31 beat has out_last=0.
